// File: rtl/commit_ctrl_pkg.sv
// Shared encodings for the commit controller: ROB head entry types,
// sequencer states and default sizing.
package commit_ctrl_pkg;

    localparam int ROB_POS_W_DEF = 4;
    localparam int REG_POS_W_DEF = 5;
    localparam int FLUSH_CYC_DEF = 2;

    typedef enum logic [1:0] {
        HT_REG    = 2'd0,
        HT_STORE  = 2'd1,
        HT_BRANCH = 2'd2,
        HT_HALT   = 2'd3
    } head_type_t;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_ST_WAIT = 2'd1,
        S_FLUSH   = 2'd2,
        S_HALTED  = 2'd3
    } state_t;

endpackage

// File: rtl/commit_ctrl.sv
// Retirement sequencer: retires the ROB head into the RegFile, handshakes
// stores with the LSB, and raises rollback on branch mispredict.
module commit_ctrl
    import commit_ctrl_pkg::*;
#(
    parameter int ROB_POS_W = ROB_POS_W_DEF,
    parameter int REG_POS_W = REG_POS_W_DEF,
    parameter int FLUSH_CYC = FLUSH_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 head_valid,
    input  logic                 head_ready,
    input  logic [1:0]           head_type,
    input  logic [REG_POS_W-1:0] head_rd,
    input  logic [31:0]          head_val,
    input  logic [ROB_POS_W-1:0] head_pos,
    input  logic                 head_mispred,
    input  logic [31:0]          head_target,
    output logic                 head_pop,
    output logic                 commit,
    output logic [REG_POS_W-1:0] commit_rd,
    output logic [31:0]          commit_val,
    output logic [ROB_POS_W-1:0] commit_rob_pos,
    output logic                 st_commit,
    output logic [ROB_POS_W-1:0] st_pos,
    input  logic                 st_done,
    output logic                 rollback,
    output logic [31:0]          rollback_pc,
    output logic                 halt,
    output logic [31:0]          retire_cnt,
    output logic [1:0]           dbg_state
);

    localparam int FW = (FLUSH_CYC < 1) ? 1 : $clog2(FLUSH_CYC + 1);

    // Handshake: a head entry is consumed only when head_valid & head_ready
    // are both high at an edge; head_pop is the ROB's one-cycle "advance"
    // strobe. st_commit/st_done form a request/complete pair with st_done
    // observed only while waiting for it.
    state_t               state_q, state_d;
    logic [FW-1:0]        flush_q, flush_d;
    logic                 gap_q, gap_d;
    logic                 pop_d, commit_d, st_commit_d, rollback_d, halt_d;
    logic [REG_POS_W-1:0] commit_rd_d;
    logic [31:0]          commit_val_d, rollback_pc_d, retire_d;
    logic [ROB_POS_W-1:0] commit_rob_pos_d, st_pos_d;

    assign dbg_state = state_q;

    always_comb begin
        state_d          = state_q;
        flush_d          = flush_q;
        gap_d            = gap_q;
        pop_d            = 1'b0;
        commit_d         = 1'b0;
        st_commit_d      = 1'b0;
        rollback_d       = 1'b0;
        halt_d           = halt;
        commit_rd_d      = commit_rd;
        commit_val_d     = commit_val;
        commit_rob_pos_d = commit_rob_pos;
        st_pos_d         = st_pos;
        rollback_pc_d    = rollback_pc;
        retire_d         = retire_cnt;

        if (rdy) begin
            // The ROB head still shows the just-popped entry for one cycle.
            if (gap_q) gap_d = 1'b0;
            case (state_q)
                S_RUN: begin
                    if (!gap_q && head_valid && head_ready) begin
                        case (head_type_t'(head_type))
                            HT_REG, HT_BRANCH: begin
                                pop_d    = 1'b1;
                                gap_d    = 1'b1;
                                retire_d = retire_cnt + 32'd1;
                                if (head_rd != '0) begin
                                    commit_d         = 1'b1;
                                    commit_rd_d      = head_rd;
                                    commit_val_d     = head_val;
                                    commit_rob_pos_d = head_pos;
                                end
                                if (head_type_t'(head_type) == HT_BRANCH && head_mispred) begin
                                    rollback_d    = 1'b1;
                                    rollback_pc_d = head_target;
                                    flush_d       = FW'(FLUSH_CYC);
                                    state_d       = S_FLUSH;
                                end
                            end
                            HT_STORE: begin
                                st_commit_d = 1'b1;
                                st_pos_d    = head_pos;
                                state_d     = S_ST_WAIT;
                            end
                            HT_HALT: begin
                                halt_d   = 1'b1;
                                pop_d    = 1'b1;
                                gap_d    = 1'b1;
                                retire_d = retire_cnt + 32'd1;
                                state_d  = S_HALTED;
                            end
                            default: ;
                        endcase
                    end
                end
                S_ST_WAIT: begin
                    if (st_done) begin
                        pop_d    = 1'b1;
                        gap_d    = 1'b1;
                        retire_d = retire_cnt + 32'd1;
                        state_d  = S_RUN;
                    end
                end
                S_FLUSH: begin
                    if (flush_q <= FW'(1)) begin
                        flush_d = '0;
                        gap_d   = 1'b0;
                        state_d = S_RUN;
                    end else begin
                        flush_d = flush_q - FW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_RUN;
            flush_q        <= '0;
            gap_q          <= 1'b0;
            head_pop       <= 1'b0;
            commit         <= 1'b0;
            commit_rd      <= '0;
            commit_val     <= '0;
            commit_rob_pos <= '0;
            st_commit      <= 1'b0;
            st_pos         <= '0;
            rollback       <= 1'b0;
            rollback_pc    <= '0;
            halt           <= 1'b0;
            retire_cnt     <= '0;
        end else begin
            state_q        <= state_d;
            flush_q        <= flush_d;
            gap_q          <= gap_d;
            head_pop       <= pop_d;
            commit         <= commit_d;
            commit_rd      <= commit_rd_d;
            commit_val     <= commit_val_d;
            commit_rob_pos <= commit_rob_pos_d;
            st_commit      <= st_commit_d;
            st_pos         <= st_pos_d;
            rollback       <= rollback_d;
            rollback_pc    <= rollback_pc_d;
            halt           <= halt_d;
            retire_cnt     <= retire_d;
        end
    end

endmodule

// File: tb/tb_commit_ctrl.sv
// Directed bench for commit_ctrl: retire timing, store handshake,
// mispredict flush window, rdy freeze, async reset and halt.
module tb_commit_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        head_valid = 1'b0;
    logic        head_ready = 1'b0;
    logic [1:0]  head_type = 2'd0;
    logic [4:0]  head_rd = '0;
    logic [31:0] head_val = '0;
    logic [3:0]  head_pos = '0;
    logic        head_mispred = 1'b0;
    logic [31:0] head_target = '0;
    logic        st_done = 1'b0;

    logic        head_pop, commit, st_commit, rollback, halt;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val, rollback_pc, retire_cnt;
    logic [3:0]  commit_rob_pos, st_pos;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_cnt = '0;
    logic [4:0]  exp_q[$];

    commit_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .head_valid(head_valid), .head_ready(head_ready), .head_type(head_type),
        .head_rd(head_rd), .head_val(head_val), .head_pos(head_pos),
        .head_mispred(head_mispred), .head_target(head_target),
        .head_pop(head_pop), .commit(commit), .commit_rd(commit_rd),
        .commit_val(commit_val), .commit_rob_pos(commit_rob_pos),
        .st_commit(st_commit), .st_pos(st_pos), .st_done(st_done),
        .rollback(rollback), .rollback_pc(rollback_pc), .halt(halt),
        .retire_cnt(retire_cnt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_head(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] v,
                            input logic [3:0] pos, input logic mp, input logic [31:0] tgt);
        head_valid = 1'b1; head_ready = 1'b1; head_type = t; head_rd = rd;
        head_val = v; head_pos = pos; head_mispred = mp; head_target = tgt;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        checks++; if ({head_pop, commit, st_commit, rollback, halt} !== 5'b0) begin errors++; $display("FAIL reset_pulses: got %b exp 00000", {head_pop, commit, st_commit, rollback, halt}); end
        checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", retire_cnt); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
        rst = 1'b1;
    endtask

    task automatic test_reg();
        set_head(2'd0, 5'd5, 32'h1234, 4'd3, 1'b0, 32'h0);
        tick(); exp_cnt++;
        checks++; if ({head_pop, commit} !== 2'b11) begin errors++; $display("FAIL reg_pop_commit: got %b exp 11", {head_pop, commit}); end
        checks++; if ({commit_rd, commit_val, commit_rob_pos} !== {5'd5, 32'h1234, 4'd3}) begin errors++; $display("FAIL reg_data: got rd=%0d val=%h pos=%0d exp rd=5 val=1234 pos=3", commit_rd, commit_val, commit_rob_pos); end
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL reg_cnt: got %0d exp %0d", retire_cnt, exp_cnt); end
        tick();
        checks++; if ({head_pop, commit} !== 2'b00) begin errors++; $display("FAIL reg_gap: got %b exp 00", {head_pop, commit}); end
        head_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [4:0]  rds[4];
        logic [31:0] vals[4];
        logic        exp_pop;
        rds = '{5'd2, 5'd0, 5'd7, 5'd9};
        vals = '{32'hA0, 32'hB1, 32'hC2, 32'hD3};
        for (int k = 0; k < 8; k++) begin
            set_head(2'd0, rds[k/2], vals[k/2], 4'(k/2 + 4), 1'b0, 32'h0);
            if (k % 2 == 0 && rds[k/2] != 5'd0) exp_q.push_back(rds[k/2]);
            tick();
            exp_pop = (k % 2 == 0);
            if (exp_pop) exp_cnt++;
            checks++; if (head_pop !== exp_pop) begin errors++; $display("FAIL b2b_pop[%0d]: got %b exp %b", k, head_pop, exp_pop); end
            checks++; if (commit !== (exp_pop && rds[k/2] != 5'd0)) begin errors++; $display("FAIL b2b_commit[%0d]: got %b exp %b", k, commit, exp_pop && rds[k/2] != 5'd0); end
            if (commit === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_sb[%0d]: got rd=%0d exp none", k, commit_rd); end
                else if (commit_rd !== exp_q[0]) begin errors++; $display("FAIL b2b_sb[%0d]: got rd=%0d exp %0d", k, commit_rd, exp_q[0]); void'(exp_q.pop_front()); end
                else void'(exp_q.pop_front());
            end
        end
        head_valid = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_sb_left: got %0d exp 0", exp_q.size()); end
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL b2b_cnt: got %0d exp %0d", retire_cnt, exp_cnt); end
    endtask

    task automatic test_store();
        set_head(2'd1, 5'd0, 32'h0, 4'd7, 1'b0, 32'h0);
        tick();
        checks++; if ({st_commit, head_pop} !== 2'b10 || st_pos !== 4'd7) begin errors++; $display("FAIL st_req: got st=%b pop=%b pos=%0d exp st=1 pop=0 pos=7", st_commit, head_pop, st_pos); end
        checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL st_state: got %0d exp 1", dbg_state); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if ({st_commit, head_pop} !== 2'b00) begin errors++; $display("FAIL st_wait[%0d]: got %b exp 00", i, {st_commit, head_pop}); end
        end
        st_done = 1'b1;
        tick(); exp_cnt++;
        checks++; if ({head_pop, commit} !== 2'b10) begin errors++; $display("FAIL st_pop: got %b exp 10", {head_pop, commit}); end
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL st_cnt: got %0d exp %0d", retire_cnt, exp_cnt); end
        st_done = 1'b0; head_valid = 1'b0;
        tick();
        checks++; if (head_pop !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL st_after: got pop=%b state=%0d exp 0 0", head_pop, dbg_state); end
    endtask

    task automatic test_branch_ok();
        set_head(2'd2, 5'd0, 32'h8, 4'd1, 1'b0, 32'h0);
        tick(); exp_cnt++;
        checks++; if ({head_pop, commit, rollback} !== 3'b100) begin errors++; $display("FAIL br_ok: got %b exp 100", {head_pop, commit, rollback}); end
        head_valid = 1'b0;
        tick();
    endtask

    task automatic test_mispredict();
        set_head(2'd2, 5'd1, 32'h44, 4'd2, 1'b1, 32'h80);
        tick(); exp_cnt++;
        checks++; if ({rollback, head_pop, commit} !== 3'b111) begin errors++; $display("FAIL mp_pulses: got %b exp 111", {rollback, head_pop, commit}); end
        checks++; if (rollback_pc !== 32'h80 || commit_rd !== 5'd1 || commit_val !== 32'h44) begin errors++; $display("FAIL mp_data: got pc=%h rd=%0d val=%h exp 80 1 44", rollback_pc, commit_rd, commit_val); end
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL mp_cnt: got %0d exp %0d", retire_cnt, exp_cnt); end
        set_head(2'd0, 5'd3, 32'h55, 4'd4, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if ({rollback, head_pop, commit} !== 3'b000) begin errors++; $display("FAIL mp_flush[%0d]: got %b exp 000", i, {rollback, head_pop, commit}); end
        end
        tick(); exp_cnt++;
        checks++; if ({head_pop, commit} !== 2'b11 || commit_rd !== 5'd3) begin errors++; $display("FAIL mp_resume: got pop/commit=%b rd=%0d exp 11 3", {head_pop, commit}, commit_rd); end
        head_valid = 1'b0;
        tick();
    endtask

    task automatic test_rdy_freeze();
        set_head(2'd1, 5'd0, 32'h0, 4'd9, 1'b0, 32'h0);
        tick();
        checks++; if (st_commit !== 1'b1) begin errors++; $display("FAIL rdy_st_req: got %b exp 1", st_commit); end
        rdy = 1'b0; st_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({st_commit, head_pop} !== 2'b00 || dbg_state !== 2'd1 || st_pos !== 4'd9) begin errors++; $display("FAIL rdy_hold[%0d]: got st/pop=%b state=%0d pos=%0d exp 00 1 9", i, {st_commit, head_pop}, dbg_state, st_pos); end
        end
        rdy = 1'b1;
        tick(); exp_cnt++;
        checks++; if (head_pop !== 1'b1 || retire_cnt !== exp_cnt) begin errors++; $display("FAIL rdy_pop: got pop=%b cnt=%0d exp 1 %0d", head_pop, retire_cnt, exp_cnt); end
        st_done = 1'b0; head_valid = 1'b0;
        tick();
        checks++; if (head_pop !== 1'b0) begin errors++; $display("FAIL rdy_single: got %b exp 0", head_pop); end
    endtask

    task automatic test_reset_in_flush();
        set_head(2'd2, 5'd2, 32'h9, 4'd5, 1'b1, 32'h100);
        tick();
        checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL rf_enter: got %0d exp 2", dbg_state); end
        #2 rst = 1'b0;
        #1;
        exp_cnt = '0;
        checks++; if ({head_pop, commit, rollback, rollback_pc, commit_rd, retire_cnt} !== '0) begin errors++; $display("FAIL rf_outputs: got pop=%b commit=%b rb=%b pc=%h rd=%0d cnt=%0d exp all 0", head_pop, commit, rollback, rollback_pc, commit_rd, retire_cnt); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rf_state: got %0d exp 0", dbg_state); end
        head_valid = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_halt();
        set_head(2'd3, 5'd0, 32'h0, 4'd6, 1'b0, 32'h0);
        tick(); exp_cnt++;
        checks++; if ({halt, head_pop} !== 2'b11 || retire_cnt !== exp_cnt || dbg_state !== 2'd3) begin errors++; $display("FAIL halt_enter: got halt/pop=%b cnt=%0d state=%0d exp 11 %0d 3", {halt, head_pop}, retire_cnt, exp_cnt, dbg_state); end
        set_head(2'd0, 5'd4, 32'h77, 4'd7, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if ({halt, head_pop, commit} !== 3'b100 || retire_cnt !== exp_cnt) begin errors++; $display("FAIL halt_sticky[%0d]: got %b cnt=%0d exp 100 %0d", i, {halt, head_pop, commit}, retire_cnt, exp_cnt); end
        end
        head_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reg();
        test_back_to_back();
        test_store();
        test_branch_ok();
        test_mispredict();
        test_rdy_freeze();
        test_reset_in_flush();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/commit_ctrl.md
Name: commit_ctrl

Overview:
- Retirement sequencer between the ROB head and RegFile.
- Inspects the ROB head entry and drives RegFile's commit port.
- Handshakes store retirement with the LSB and issues the rollback pulse on branch mispredict, then holds for a flush window.
- Retires at most one instruction per two cycles; maintains halt and retired-instruction count.

Parameters:
ROB_POS_W, 4, ROB index width (RegFile rename tag = {1'b1, pos}, 5 bits)
REG_POS_W, 5, architectural register index width
FLUSH_CYC, 2, cycles held in FLUSH after rollback (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
rdy  in  1  global ready; state frozen when 0
head_valid  in  1  ROB non-empty
head_ready  in  1  head result available
head_type  in  2  0 REG, 1 STORE, 2 BRANCH, 3 HALT
head_rd  in  REG_POS_W  destination register
head_val  in  32  result / link value
head_pos  in  ROB_POS_W  head ROB index
head_mispred  in  1  branch resolved mispredicted
head_target  in  32  correct PC for mispredict
head_pop  out  1  pulse: ROB advances head
commit  out  1  pulse to RegFile
commit_rd  out  REG_POS_W  to RegFile
commit_val  out  32  to RegFile
commit_rob_pos  out  ROB_POS_W  to RegFile
st_commit  out  1  pulse: LSB may perform store
st_pos  out  ROB_POS_W  store ROB index
st_done  in  1  LSB store completed
rollback  out  1  pulse: global flush (RegFile, ROB, RS, LSB)
rollback_pc  out  32  fetch redirect PC
halt  out  1  sticky halt
retire_cnt  out  32  retired instructions, wraps mod 2^32

Behaviour:
- All outputs registered. On rst=0 all outputs 0, state RUN, flush counter 0, gap flag 0.
- rdy=0: state, counters and data outputs hold; pulse outputs (head_pop, commit, st_commit, rollback) are 0 after the next edge.
- Pulses last exactly one cycle.
- head_pop and commit for the same entry assert in the same cycle.
- gap flag is set by every head_pop. While set, the head is ignored for one cycle, then the flag clears. Gives 2-cycle retire throughput.
- RUN, no gap, head_valid & head_ready:
  - REG: head_pop=1; commit=(head_rd!=0) with rd/val/pos copied; retire_cnt+1.
  - STORE: st_commit=1, st_pos=head_pos; go ST_WAIT; no pop yet.
  - BRANCH, head_mispred=0: head_pop=1; commit if head_rd!=0 (link); retire_cnt+1.
  - BRANCH, head_mispred=1: rollback=1, rollback_pc=head_target; head_pop=1; link commit if head_rd!=0; retire_cnt+1; load counter FLUSH_CYC; go FLUSH. RegFile sees commit and rollback in the same cycle.
  - HALT: halt=1, head_pop=1, retire_cnt+1, go HALTED.
- RUN with head_valid=0 or head_ready=0: idle, no outputs.
- ST_WAIT:
  - Wait on st_done, no timeout.
  - st_done=1: head_pop=1, retire_cnt+1, return to RUN with gap set.
  - st_done outside ST_WAIT is ignored.
- FLUSH:
  - Counter decrements each rdy cycle; head inputs ignored.
  - At 0, return to RUN; gap is cleared.
- HALTED: absorbing until reset; no further pulses.
- Async reset in any state, including ST_WAIT or FLUSH, aborts immediately; no pending pop survives.
- retire_cnt 32'hFFFFFFFF + 1 -> 0.

Decomposition:
- Mydefine.v adds: head_type codes (`HT_REG/`HT_STORE/`HT_BRANCH/`HT_HALT), state encodings, FLUSH_CYC default.
- Mydefine.v reuses: existing ROB_POS_WID and REG_POS_WID.
- Single flat module; FSM plus flush counter are too small to justify a submodule.

Test Plan:
- Reset then REG head rd=5 val=0x1234 pos=3 ready -> cycle1 head_pop=1, commit=1, commit_rd=5, commit_val=0x1234, commit_rob_pos=3, retire_cnt=1; next cycle no pop (gap).
- Four back-to-back REG heads held ready -> pops on alternate cycles, retire_cnt=4 after 8 cycles; rd=0 entry pops with commit=0.
- STORE pos=7, st_done after 5 cycles -> st_commit=1 for 1 cycle with st_pos=7; head_pop only in the cycle after st_done; retire_cnt+1 once.
- BRANCH mispred target=0x80, rd=1, val=0x44 -> same cycle rollback=1, rollback_pc=0x80, commit_rd=1, head_pop=1; ready heads ignored for FLUSH_CYC=2 cycles, then retire resumes.
- rdy=0 mid ST_WAIT with st_done pulsing -> no pop; after rdy=1 and st_done -> single pop. rst=0 during FLUSH -> all outputs 0 immediately, state RUN.
- HALT head -> halt=1 sticky, retire_cnt+1; later valid REG heads produce no pulses.
